// File: rtl/x3gray_decade_counter.sv
// Decade up/down counter with Excess-3-Gray outputs.
// It cascades through ent/rco and feeds an XS3-Gray decoder directly.
module x3gray_decade_counter (
    input  logic       clk,
    input  logic       clr_,
    input  logic       load_,
    input  logic       enp,
    input  logic       ent,
    input  logic       up,
    input  logic [3:0] din,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [3:0] q_bcd,
    output logic       rco,
    output logic       err
);

    logic [3:0] n;
    logic [3:0] code;
    logic       at_max;
    logic       at_min;

    assign at_max = (n == 4'd9);
    assign at_min = (n == 4'd0);

    // State update: clear beats load, load beats count, else hold.
    // A load value above 9 is refused, and err flags it for one cycle.
    always_ff @(posedge clk) begin
        if (!clr_) begin
            n   <= 4'd0;
            err <= 1'b0;
        end else if (!load_) begin
            if (din <= 4'd9) begin
                n   <= din;
                err <= 1'b0;
            end else begin
                err <= 1'b1;
            end
        end else if (enp && ent) begin
            err <= 1'b0;
            if (up) begin
                n <= at_max ? 4'd0 : n + 4'd1;
            end else begin
                n <= at_min ? 4'd9 : n - 4'd1;
            end
        end else begin
            err <= 1'b0;
        end
    end

    // Gray(n+3) lookup from the registered count.
    // Neighbouring counts, including 9 and 0, differ in one bit.
    always_comb begin
        code = 4'b0010;
        case (n)
            4'd0:    code = 4'b0010;
            4'd1:    code = 4'b0110;
            4'd2:    code = 4'b0111;
            4'd3:    code = 4'b0101;
            4'd4:    code = 4'b0100;
            4'd5:    code = 4'b1100;
            4'd6:    code = 4'b1101;
            4'd7:    code = 4'b1111;
            4'd8:    code = 4'b1110;
            4'd9:    code = 4'b1010;
            default: code = 4'b0010;
        endcase
    end

    assign {d, c, b, a} = code;
    assign q_bcd        = n;

    // Terminal count follows ent and up without waiting for a clock edge.
    assign rco = ent & (up ? at_max : at_min);

endmodule

// File: tb/tb_x3gray_decade_counter.sv
// Bench for x3gray_decade_counter: directed steps with a scoreboard,
// plus a two-digit cascade that is run through one full 00..99 cycle.
module tb_x3gray_decade_counter;

    logic       clk = 1'b0;
    logic       clr_, load_, enp, ent, up;
    logic [3:0] din;
    logic       a, b, c, d, rco, err;
    logic [3:0] q_bcd;

    logic       c_clr;
    logic       c0_a, c0_b, c0_c, c0_d, c0_rco, c0_err;
    logic       c1_a, c1_b, c1_c, c1_d, c1_rco, c1_err;
    logic [3:0] c0_q, c1_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] q;
        logic       e;
    } exp_t;

    exp_t sb[$];

    logic [3:0] gray_tbl [10] = '{
        4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010
    };

    int m = 0;

    always #5 clk = ~clk;

    x3gray_decade_counter dut (
        .clk(clk), .clr_(clr_), .load_(load_), .enp(enp), .ent(ent),
        .up(up), .din(din), .a(a), .b(b), .c(c), .d(d),
        .q_bcd(q_bcd), .rco(rco), .err(err)
    );

    x3gray_decade_counter c0 (
        .clk(clk), .clr_(c_clr), .load_(1'b1), .enp(1'b1), .ent(1'b1),
        .up(1'b1), .din(4'd0), .a(c0_a), .b(c0_b), .c(c0_c), .d(c0_d),
        .q_bcd(c0_q), .rco(c0_rco), .err(c0_err)
    );

    x3gray_decade_counter c1 (
        .clk(clk), .clr_(c_clr), .load_(1'b1), .enp(1'b1), .ent(c0_rco),
        .up(1'b1), .din(4'd0), .a(c1_a), .b(c1_b), .c(c1_c), .d(c1_d),
        .q_bcd(c1_q), .rco(c1_rco), .err(c1_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict, clock, then compare.
    task automatic step(input logic cl, input logic ld, input logic p,
                        input logic t, input logic u, input logic [3:0] dv,
                        input string tag);
        exp_t x;
        logic ee;
        clr_ = cl; load_ = ld; enp = p; ent = t; up = u; din = dv;
        ee = 1'b0;
        if (!cl) begin
            m = 0;
        end else if (!ld) begin
            if (dv <= 4'd9) m = int'(dv);
            else ee = 1'b1;
        end else if (p && t) begin
            m = u ? (m + 1) % 10 : (m + 9) % 10;
        end
        x.code = gray_tbl[m];
        x.q    = 4'(m);
        x.e    = ee;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({tag, ".code"}, {4'h0, d, c, b, a}, {4'h0, x.code});
        chk({tag, ".q"}, {4'h0, q_bcd}, {4'h0, x.q});
        chk({tag, ".err"}, {7'h0, err}, {7'h0, x.e});
        chk({tag, ".rco"}, {7'h0, rco},
            {7'h0, t & (u ? (m == 9) : (m == 0))});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        logic [3:0] lo_code, hi_code, lo_prev, hi_prev;
        int lo_ent [10];
        int hi_ent [10];

        c_clr = 1'b0;
        clr_ = 1'b1; load_ = 1'b1; enp = 1'b0; ent = 1'b1; up = 1'b1;
        din = 4'd0;
        @(negedge clk);

        // 1: reset
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "rst");
        up = 1'b0;
        #1;
        chk("rst.rco_dn", {7'h0, rco}, 8'h01);
        up = 1'b1;
        #1;

        // 2: twelve up counts, one bit toggling each time
        for (int i = 0; i < 12; i++) begin
            prev = {d, c, b, a};
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "up");
            chk("up.onebit", 8'($countones(prev ^ {d, c, b, a})), 8'd1);
        end

        // 3: valid and invalid loads
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, "ld7");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd12, "ld12");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "ld_after");

        // 4: count down across the wrap, then ent gating
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "ld1");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "dn");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "ld0");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "ent0");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "dir_up");

        // 5: enp low holds, clear beats load
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "hold");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd14, "ld14");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, "clr_ld");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd13, "clr_bad");

        // 6: cascaded pair, 100 edges from 00
        for (int k = 0; k < 10; k++) begin
            lo_ent[k] = 0;
            hi_ent[k] = 0;
        end
        @(posedge clk);
        #1;
        chk("cas.rst_lo", {4'h0, c0_q}, 8'h00);
        chk("cas.rst_hi", {4'h0, c1_q}, 8'h00);
        lo_prev = {c0_d, c0_c, c0_b, c0_a};
        hi_prev = {c1_d, c1_c, c1_b, c1_a};
        c_clr = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            lo_code = {c0_d, c0_c, c0_b, c0_a};
            hi_code = {c1_d, c1_c, c1_b, c1_a};
            chk("cas.lo", {4'h0, c0_q}, 8'(i % 10));
            chk("cas.hi", {4'h0, c1_q}, 8'((i / 10) % 10));
            chk("cas.rco", {7'h0, c0_rco}, {7'h0, (i % 10) == 9});
            for (int k = 0; k < 10; k++) begin
                if (lo_code == gray_tbl[k] && lo_prev != gray_tbl[k])
                    lo_ent[k]++;
                if (hi_code == gray_tbl[k] && hi_prev != gray_tbl[k])
                    hi_ent[k]++;
            end
            lo_prev = lo_code;
            hi_prev = hi_code;
        end
        for (int k = 0; k < 10; k++) begin
            chk("cas.lo_line", 8'(lo_ent[k]), 8'd10);
            chk("cas.hi_line", 8'(hi_ent[k]), 8'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
